// File: rtl/ss_sequencer.sv
// Host-side press/release sequencer for the single-step core: steps N cycles, N instructions, or free-runs.
// Optional WAIT_SYNC watchdog built when SS_TIMEOUT_EN is defined.
module ss_sequencer #(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned PRESS_CYC   = 4,
    parameter int unsigned RELEASE_CYC = 3
`ifdef SS_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYC = 255
`endif
) (
    input  logic             phi2,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             sync,
    output logic             ss,
    output logic             si_n,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] steps_done,
    output logic             timeout
);

    localparam int unsigned PR_MAX = (PRESS_CYC > RELEASE_CYC) ? PRESS_CYC : RELEASE_CYC;
`ifdef SS_TIMEOUT_EN
    localparam int unsigned TMR_MAX = (TIMEOUT_CYC > PR_MAX) ? TIMEOUT_CYC : PR_MAX;
`else
    localparam int unsigned TMR_MAX = PR_MAX;
`endif
    localparam int unsigned TMR_W = $clog2(TMR_MAX);

    localparam logic [1:0] OP_HALT     = 2'b00;
    localparam logic [1:0] OP_STEP_CYC = 2'b01;
    localparam logic [1:0] OP_STEP_INS = 2'b10;
    localparam logic [1:0] OP_RUN      = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS,
        S_WAIT_SYNC,
        S_RELEASE,
        S_RUN
    } state_t;

    state_t             state, state_nxt;
    logic [TMR_W-1:0]   timer, timer_nxt;
    logic [CNT_W-1:0]   count_q, count_nxt;
    logic               instr_q, instr_nxt;
    logic               ending_q, ending_nxt;
    logic [CNT_W-1:0]   steps_nxt, steps_inc;
    logic               ss_nxt, si_n_nxt, busy_nxt, done_nxt, ready_nxt;
    logic               accept, abort;

    assign accept    = cmd_valid && cmd_ready;
    assign abort     = cmd_valid && (cmd_op == OP_HALT) && (state != S_IDLE);
    assign steps_inc = (&steps_done) ? steps_done : steps_done + CNT_W'(1);

`ifdef SS_TIMEOUT_EN
    logic timeout_q, timeout_nxt;
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    // Next-state, counters and registered-output decode.
    always_comb begin
        state_nxt  = state;
        timer_nxt  = timer + TMR_W'(1);
        count_nxt  = count_q;
        instr_nxt  = instr_q;
        ending_nxt = ending_q;
        steps_nxt  = steps_done;
        done_nxt   = 1'b0;
`ifdef SS_TIMEOUT_EN
        timeout_nxt = timeout_q;
`endif

        case (state)
            S_IDLE: begin
                if (accept) begin
                    count_nxt  = (cmd_count == '0) ? CNT_W'(1) : cmd_count;
                    steps_nxt  = '0;
                    ending_nxt = 1'b0;
                    timer_nxt  = '0;
`ifdef SS_TIMEOUT_EN
                    timeout_nxt = 1'b0;
`endif
                    case (cmd_op)
                        OP_STEP_CYC: begin state_nxt = S_PRESS; instr_nxt = 1'b0; end
                        OP_STEP_INS: begin state_nxt = S_PRESS; instr_nxt = 1'b1; end
                        OP_RUN:      begin state_nxt = S_RUN;   instr_nxt = 1'b0; end
                        OP_HALT:     state_nxt = S_IDLE;
                    endcase
                end
            end
            S_PRESS: begin
                if (timer == TMR_W'(PRESS_CYC - 1)) begin
                    timer_nxt = '0;
                    if (instr_q) begin
                        state_nxt = S_WAIT_SYNC;
                    end else begin
                        state_nxt = S_RELEASE;
                        steps_nxt = steps_inc;
                    end
                end
            end
            S_WAIT_SYNC: begin
                if (sync) begin
                    state_nxt = S_RELEASE;
                    timer_nxt = '0;
                    steps_nxt = steps_inc;
                end
`ifdef SS_TIMEOUT_EN
                else if (timer == TMR_W'(TIMEOUT_CYC - 1)) begin
                    state_nxt   = S_RELEASE;
                    timer_nxt   = '0;
                    ending_nxt  = 1'b1;
                    timeout_nxt = 1'b1;
                end
`endif
            end
            S_RELEASE: begin
                if (timer == TMR_W'(RELEASE_CYC - 1)) begin
                    timer_nxt = '0;
                    if (ending_q || (steps_done >= count_q)) begin
                        state_nxt = S_IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = S_PRESS;
                    end
                end
            end
            S_RUN:   state_nxt = S_RUN;
            default: state_nxt = S_IDLE;
        endcase

        // A halt while busy overrides everything: drop ss, leave instruction mode, no step credit.
        if (abort) begin
            state_nxt  = S_RELEASE;
            timer_nxt  = '0;
            ending_nxt = 1'b1;
            instr_nxt  = 1'b0;
            steps_nxt  = steps_done;
        end

        ss_nxt    = (state_nxt == S_PRESS) || (state_nxt == S_WAIT_SYNC) || (state_nxt == S_RUN);
        busy_nxt  = (state_nxt != S_IDLE);
        ready_nxt = (state_nxt == S_IDLE);
        case (state_nxt)
            S_PRESS, S_RELEASE: si_n_nxt = ~instr_nxt;
            S_WAIT_SYNC, S_RUN: si_n_nxt = 1'b0;
            default:            si_n_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge phi2) begin
        if (reset) begin
            state      <= S_IDLE;
            timer      <= '0;
            count_q    <= '0;
            instr_q    <= 1'b0;
            ending_q   <= 1'b0;
            steps_done <= '0;
            ss         <= 1'b0;
            si_n       <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            cmd_ready  <= 1'b1;
        end else begin
            state      <= state_nxt;
            timer      <= timer_nxt;
            count_q    <= count_nxt;
            instr_q    <= instr_nxt;
            ending_q   <= ending_nxt;
            steps_done <= steps_nxt;
            ss         <= ss_nxt;
            si_n       <= si_n_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            cmd_ready  <= ready_nxt;
        end
    end

`ifdef SS_TIMEOUT_EN
    always_ff @(posedge phi2) begin
        if (reset) timeout_q <= 1'b0;
        else       timeout_q <= timeout_nxt;
    end
`endif

endmodule

// File: tb/tb_ss_sequencer.sv
// Self-checking bench for ss_sequencer: expected waveforms come from per-command timeline arithmetic.
// Timeout scenario is included when SS_TIMEOUT_EN is defined.
module tb_ss_sequencer;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned PC    = 4;
    localparam int unsigned RC    = 3;
`ifdef SS_TIMEOUT_EN
    localparam int unsigned TO    = 255;
`endif

    logic             phi2 = 1'b0;
    logic             reset, cmd_valid, cmd_ready, sync;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_count, steps_done;
    logic             ss, si_n, busy, done, timeout;

    int               n_assert = 0;
    int               n_fail   = 0;
    int               cyc      = 0;
    logic [CNT_W-1:0] cur_steps;
    logic             cur_to;

    ss_sequencer dut (
        .phi2       (phi2),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_count  (cmd_count),
        .sync       (sync),
        .ss         (ss),
        .si_n       (si_n),
        .busy       (busy),
        .done       (done),
        .steps_done (steps_done),
        .timeout    (timeout)
    );

    always #5 phi2 = ~phi2;

    function automatic logic rbit();
        return 1'($urandom);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, clock once, and check every output against the expected values.
    task automatic step(input logic rst, input logic vld, input logic [1:0] op,
                        input logic [CNT_W-1:0] cnt, input logic syn,
                        input logic e_ss, input logic e_si_n, input logic e_busy,
                        input logic e_done, input logic [CNT_W-1:0] e_steps, input logic e_to);
        reset     = rst;
        cmd_valid = vld;
        cmd_op    = op;
        cmd_count = cnt;
        sync      = syn;
        @(posedge phi2);
        #1;
        cyc++;
        chk("ss",         32'(ss),         32'(e_ss));
        chk("si_n",       32'(si_n),       32'(e_si_n));
        chk("busy",       32'(busy),       32'(e_busy));
        chk("cmd_ready",  32'(cmd_ready),  32'(!e_busy));
        chk("done",       32'(done),       32'(e_done));
        chk("steps_done", 32'(steps_done), 32'(e_steps));
        chk("timeout",    32'(timeout),    32'(e_to));
    endtask

    // Busy cycle with random non-halt commands that must be ignored.
    task automatic busy_step(input logic syn, input logic e_ss, input logic e_si_n,
                             input logic [CNT_W-1:0] e_steps);
        step(1'b0, 1'($urandom_range(1)), 2'($urandom_range(3, 1)), CNT_W'($urandom), syn,
             e_ss, e_si_n, 1'b1, 1'b0, e_steps, cur_to);
    endtask

    task automatic accept_step(input logic [1:0] op, input logic [CNT_W-1:0] cnt,
                               input logic e_ss, input logic e_si_n);
        cur_to = 1'b0;
        step(1'b0, 1'b1, op, cnt, rbit(), e_ss, e_si_n, 1'b1, 1'b0, '0, 1'b0);
    endtask

    task automatic done_step(input logic [CNT_W-1:0] e_steps);
        cur_steps = e_steps;
        step(1'b0, 1'($urandom_range(1)), 2'($urandom_range(3, 1)), CNT_W'($urandom), rbit(),
             1'b0, 1'b1, 1'b0, 1'b1, e_steps, cur_to);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            step(1'b0, 1'b0, 2'($urandom), CNT_W'($urandom), rbit(),
                 1'b0, 1'b1, 1'b0, 1'b0, cur_steps, cur_to);
    endtask

    // Halt while busy: ss low with si_n=1 for the release window, then done with no extra step.
    task automatic abort_tail(input logic [CNT_W-1:0] s);
        step(1'b0, 1'b1, 2'b00, CNT_W'($urandom), rbit(), 1'b0, 1'b1, 1'b1, 1'b0, s, cur_to);
        for (int k = 1; k < RC; k++) busy_step(rbit(), 1'b0, 1'b1, s);
        done_step(s);
    endtask

    task automatic cmd_cycles(input int n, input int ab_step, input int ab_off);
        int ne;
        ne = (n == 0) ? 1 : n;
        for (int i = 0; i < ne; i++) begin
            for (int j = 0; j < PC; j++) begin
                if (i == 0 && j == 0) accept_step(2'b01, CNT_W'(n), 1'b1, 1'b1);
                else                  busy_step(rbit(), 1'b1, 1'b1, CNT_W'(i));
                if (i == ab_step && j == ab_off) begin
                    abort_tail(CNT_W'(i));
                    return;
                end
            end
            for (int j = 0; j < RC; j++) busy_step(rbit(), 1'b0, 1'b1, CNT_W'(i + 1));
        end
        done_step(CNT_W'(ne));
    endtask

    // Each instruction step: ss high for d cycles, sync sampled on the d-th edge after the press.
    task automatic cmd_instr(input int n);
        int ne, d;
        ne = (n == 0) ? 1 : n;
        for (int i = 0; i < ne; i++) begin
            d = int'($urandom_range(14, 5));
            for (int j = 0; j < d; j++) begin
                if (i == 0 && j == 0) accept_step(2'b10, CNT_W'(n), 1'b1, 1'b0);
                else busy_step((j >= 5) ? 1'b0 : rbit(), 1'b1, 1'b0, CNT_W'(i));
            end
            busy_step(1'b1, 1'b0, 1'b0, CNT_W'(i + 1));
            for (int j = 1; j < RC; j++) busy_step(rbit(), 1'b0, 1'b0, CNT_W'(i + 1));
        end
        done_step(CNT_W'(ne));
    endtask

    task automatic cmd_run(input int r);
        accept_step(2'b11, CNT_W'($urandom), 1'b1, 1'b0);
        for (int k = 1; k < r; k++) busy_step(rbit(), 1'b1, 1'b0, '0);
        abort_tail('0);
    endtask

    task automatic reset_mid(input int k);
        accept_step(2'b01, CNT_W'(5), 1'b1, 1'b1);
        for (int j = 0; j < k; j++) busy_step(rbit(), 1'b1, 1'b1, '0);
        cur_steps = '0;
        cur_to    = 1'b0;
        step(1'b1, 1'b1, 2'b01, CNT_W'(5), rbit(), 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    endtask

`ifdef SS_TIMEOUT_EN
    task automatic cmd_timeout();
        accept_step(2'b10, CNT_W'($urandom_range(255, 1)), 1'b1, 1'b0);
        for (int j = 1; j < PC + TO; j++) busy_step((j >= 5) ? 1'b0 : rbit(), 1'b1, 1'b0, '0);
        cur_to = 1'b1;
        busy_step(1'b0, 1'b0, 1'b0, '0);
        for (int j = 1; j < RC; j++) busy_step(rbit(), 1'b0, 1'b0, '0);
        done_step('0);
    endtask
`endif

    initial begin
        int n, ab;
        cur_steps = '0;
        cur_to    = 1'b0;
        step(1'b1, 1'b0, 2'b00, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, 2'b01, '0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        idle(2);

        cmd_cycles(3, -1, 0);
        idle(1);
        cmd_instr(2);
        cmd_cycles(0, -1, 0);
        cmd_cycles(5, 2, int'($urandom_range(3)));
        idle(1);
        cmd_run(50);
        idle(1);

        for (int k = 0; k < 4; k++) begin
            n  = int'($urandom_range(4));
            ab = ($urandom_range(1) == 1) ? int'($urandom_range((n == 0) ? 0 : n - 1)) : -1;
            cmd_cycles(n, ab, int'($urandom_range(3)));
            cmd_instr(int'($urandom_range(3, 1)));
            idle(int'($urandom_range(2)));
        end

        reset_mid(2);
        idle(2);
        cmd_cycles(1, -1, 0);

`ifdef SS_TIMEOUT_EN
        cmd_timeout();
        idle(2);
        cmd_cycles(1, -1, 0);
`endif
        idle(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
